// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the CNN streaming blocks.
//   DEFAULT_DATA_WIDTH : default sample width (signed two's complement)
//   lane_lsb()         : LSB position of a channel lane inside a packed beat;
//                        every block packs channel c at [c*width +: width]
// -----------------------------------------------------------------------------
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// -----------------------------------------------------------------------------
// max_cmp
// Combinational signed two-input maximum.
// Ports:
//   a_i, b_i : signed operands, DATA_WIDTH bits
//   max_o    : the larger operand (equal operands: either one is correct)
// -----------------------------------------------------------------------------
module max_cmp #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] max_o
);

  assign max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;

endmodule

// File: rtl/max_pool_stream.sv
// -----------------------------------------------------------------------------
// max_pool_stream
// Streaming 2x2 / stride-2 max pooling over a raster-ordered feature map.
// Depth channels travel in parallel lanes. Output latency is one cycle from
// the beat that completes a window.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   in_data    : one pixel, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   : in_data valid
//   in_ready   : beat accepted when in_valid && in_ready
//   out_data   : one pooled pixel, same lane packing as in_data
//   out_valid  : out_data valid, held until accepted
//   out_ready  : downstream accepts out_data
//   frame_done : high in the cycle the last pooled pixel of a frame is accepted
//
// Build option:
//   MAXPOOL_RELU_EN : when defined, negative pooled lanes are clamped to 0
//                     before they enter the output register.
// -----------------------------------------------------------------------------
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int InputH     = 28,
  parameter int InputW     = 28,
  parameter int Depth      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [Depth*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [Depth*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        frame_done
);

  localparam int CW       = (InputW > 1) ? $clog2(InputW) : 1;
  localparam int RW       = (InputH > 1) ? $clog2(InputH) : 1;
  localparam int LB_DEPTH = (InputW / 2 > 0) ? InputW / 2 : 1;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(InputW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(InputH - 1);

  if ((InputH % 2) != 0 || (InputW % 2) != 0 || InputH < 2 || InputW < 2) begin : g_bad_dims
    $error("max_pool_stream: InputH and InputW must be even and at least 2");
  end

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           out_valid_q, out_valid_d;
  logic           last_q, last_d;
  logic           beat;
  logic           load_win;
  logic [LBW-1:0] lb_addr;

  // The output register may take a new result whenever it is empty or being
  // drained this cycle, which gives back-to-back results with no bubble.
  assign in_ready   = !out_valid_q || out_ready;
  assign beat       = in_valid && in_ready;
  // A window completes on the odd column of an odd row.
  assign load_win   = beat && row_q[0] && col_q[0];
  assign lb_addr    = LBW'(col_q >> 1);
  assign out_valid  = out_valid_q;
  assign frame_done = out_valid_q && out_ready && last_q;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (beat) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (load_win) begin
      out_valid_d = 1'b1;
      last_d      = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  for (genvar gi = 0; gi < Depth; gi++) begin : g_lane
    localparam int LSB = lane_lsb(gi, DATA_WIDTH);

    logic [DATA_WIDTH-1:0] pix;
    logic [DATA_WIDTH-1:0] pair_q;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] lb_rd_q;
    logic [DATA_WIDTH-1:0] win_max;
    logic [DATA_WIDTH-1:0] res;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] lb_mem [LB_DEPTH];

    assign pix = in_data[LSB +: DATA_WIDTH];

    // Horizontal pair: captured even-column pixel vs current odd-column pixel.
    max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
      .a_i  (pair_q),
      .b_i  (pix),
      .max_o(pair_max)
    );

    // Vertical combine: even-row pair maximum vs odd-row pair maximum.
    max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_win (
      .a_i  (lb_rd_q),
      .b_i  (pair_max),
      .max_o(win_max)
    );

`ifdef MAXPOOL_RELU_EN
    assign res = win_max[DATA_WIDTH-1] ? '0 : win_max;
`else
    assign res = win_max;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        pair_q <= '0;
        out_q  <= '0;
      end else begin
        if (beat && !col_q[0]) begin
          pair_q <= pix;
        end
        if (load_win) begin
          out_q <= res;
        end
      end
    end

    // Line buffer with a registered read. The read is issued on the even
    // column, which shares col/2 with the odd column that consumes it, so the
    // data is ready when the window completes. Writes happen on even rows and
    // reads matter only on odd rows, so the two never collide.
    always_ff @(posedge clk) begin
      if (beat && !row_q[0] && col_q[0]) begin
        lb_mem[lb_addr] <= pair_max;
      end
      if (beat && !col_q[0]) begin
        lb_rd_q <= lb_mem[lb_addr];
      end
    end

    assign out_data[LSB +: DATA_WIDTH] = out_q;
  end

endmodule

// File: tb/tb_max_pool_stream.sv
module tb_max_pool_stream;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] tb_in;
  logic        tb_valid;
  logic        tb_oready;
  logic [1:0]  sel;

  wire  [3:0]  irdy;
  wire  [3:0]  oval;
  wire  [3:0]  fdone;
  wire  [15:0] od0, od1, od3;
  wire  [31:0] od2;

  logic        cur_irdy, cur_oval, cur_fdone;
  logic [31:0] cur_odat;

  // 0: 4x4 D1, 1: 2x2 D1, 2: 4x4 D2, 3: 28x28 D1
  max_pool_stream #(.DATA_WIDTH(16), .InputH(4), .InputW(4), .Depth(1)) u_d0 (
    .clk(clk), .reset(reset), .in_data(tb_in[15:0]), .in_valid(tb_valid && (sel == 2'd0)),
    .in_ready(irdy[0]), .out_data(od0), .out_valid(oval[0]), .out_ready(tb_oready),
    .frame_done(fdone[0]));
  max_pool_stream #(.DATA_WIDTH(16), .InputH(2), .InputW(2), .Depth(1)) u_d1 (
    .clk(clk), .reset(reset), .in_data(tb_in[15:0]), .in_valid(tb_valid && (sel == 2'd1)),
    .in_ready(irdy[1]), .out_data(od1), .out_valid(oval[1]), .out_ready(tb_oready),
    .frame_done(fdone[1]));
  max_pool_stream #(.DATA_WIDTH(16), .InputH(4), .InputW(4), .Depth(2)) u_d2 (
    .clk(clk), .reset(reset), .in_data(tb_in), .in_valid(tb_valid && (sel == 2'd2)),
    .in_ready(irdy[2]), .out_data(od2), .out_valid(oval[2]), .out_ready(tb_oready),
    .frame_done(fdone[2]));
  max_pool_stream #(.DATA_WIDTH(16), .InputH(28), .InputW(28), .Depth(1)) u_d3 (
    .clk(clk), .reset(reset), .in_data(tb_in[15:0]), .in_valid(tb_valid && (sel == 2'd3)),
    .in_ready(irdy[3]), .out_data(od3), .out_valid(oval[3]), .out_ready(tb_oready),
    .frame_done(fdone[3]));

  always_comb begin
    cur_irdy  = irdy[sel];
    cur_oval  = oval[sel];
    cur_fdone = fdone[sel];
    case (sel)
      2'd0:    cur_odat = {16'h0, od0};
      2'd1:    cur_odat = {16'h0, od1};
      2'd2:    cur_odat = od2;
      default: cur_odat = {16'h0, od3};
    endcase
  end

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct packed {
    logic [1:0]        sel;
    logic [4:0]        npix;
    logic [2:0]        nout;
    logic [15:0][31:0] pix;
    logic [3:0][31:0]  expv;
  } vec_t;
  vec_t vecs [3];

  logic [15:0] frm [784];

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] w16(input int v);
    return {16'h0, v[15:0]};
  endfunction

  function automatic logic [31:0] pk(input int hi, input int lo);
    return {hi[15:0], lo[15:0]};
  endfunction

  function automatic int sx(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, a transfer happens at
  // the next rising edge when out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && cur_oval && tb_oready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none (dut %0d)", cur_odat, sel);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_data", cur_odat, mon_e.d);
        chk("frame_done", 32'(cur_fdone), 32'(mon_e.last));
        $display("out dut=%0d data=%08h frame_done=%0d", sel, cur_odat, cur_fdone);
      end
      if (cur_fdone) fd_cnt++;
    end else if (!reset && cur_fdone) begin
      checks++;
      errors++;
      $display("FAIL stray_frame_done: got 1 expected 0 (dut %0d)", sel);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    bit acc;
    acc = 1'b0;
    tb_in = d;
    tb_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = cur_irdy;
      @(posedge clk);
      #1;
    end
    tb_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || cur_oval) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(sbq.size()), 32'd0);
  endtask

  task automatic apply_vec(input int i);
    int f0;
    sel = vecs[i].sel;
    tb_oready = 1'b1;
    f0 = fd_cnt;
    for (int k = 0; k < int'(vecs[i].nout); k++)
      sbq.push_back({vecs[i].expv[k], k == int'(vecs[i].nout) - 1});
    for (int k = 0; k < int'(vecs[i].npix); k++)
      send(vecs[i].pix[k]);
    drain("vec_drain");
    chk("vec_frame_done_count", 32'(fd_cnt - f0), 32'd1);
  endtask

  task automatic push_ramp4();
    sbq.push_back({w16(relu(6)), 1'b0});
    sbq.push_back({w16(relu(8)), 1'b0});
    sbq.push_back({w16(relu(14)), 1'b0});
    sbq.push_back({w16(relu(16)), 1'b1});
  endtask

  bit rnd_en;

  initial begin
    int f0;
    int m;
    vecs[0] = '0;
    vecs[0].sel = 2'd0; vecs[0].npix = 5'd16; vecs[0].nout = 3'd4;
    for (int k = 0; k < 16; k++) vecs[0].pix[k] = w16(k + 1);
    vecs[0].expv[0] = w16(relu(6));  vecs[0].expv[1] = w16(relu(8));
    vecs[0].expv[2] = w16(relu(14)); vecs[0].expv[3] = w16(relu(16));

    vecs[1] = '0;
    vecs[1].sel = 2'd1; vecs[1].npix = 5'd4; vecs[1].nout = 3'd1;
    vecs[1].pix[0] = w16(-5); vecs[1].pix[1] = w16(-3);
    vecs[1].pix[2] = w16(-8); vecs[1].pix[3] = w16(-2);
    vecs[1].expv[0] = w16(relu(-2));

    vecs[2] = '0;
    vecs[2].sel = 2'd2; vecs[2].npix = 5'd16; vecs[2].nout = 3'd4;
    for (int k = 0; k < 16; k++) vecs[2].pix[k] = pk(-(k + 1), k + 1);
    vecs[2].expv[0] = pk(relu(-1), relu(6));
    vecs[2].expv[1] = pk(relu(-3), relu(8));
    vecs[2].expv[2] = pk(relu(-9), relu(14));
    vecs[2].expv[3] = pk(relu(-11), relu(16));

    // Reset state, checked while reset is still high.
    reset = 1'b1; tb_in = '0; tb_valid = 1'b0; tb_oready = 1'b0; sel = 2'd0; rnd_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("reset_out_valid", 32'(cur_oval), 32'd0);
      chk("reset_in_ready", 32'(cur_irdy), 32'd1);
      chk("reset_out_data", cur_odat, 32'd0);
      chk("reset_frame_done", 32'(cur_fdone), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Table-driven frames: 4x4 ramp, 2x2 negatives, 2-lane ramp/negated ramp.
    for (int i = 0; i < 3; i++) apply_vec(i);

    // Downstream stall right after the first result.
    sel = 2'd0; tb_oready = 1'b0; f0 = fd_cnt;
    push_ramp4();
    for (int k = 1; k <= 6; k++) send(w16(k));
    tb_in = w16(7);
    tb_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(cur_irdy), 32'd0);
      chk("stall_out_valid", 32'(cur_oval), 32'd1);
      chk("stall_out_data", cur_odat, w16(relu(6)));
    end
    @(posedge clk); #1;
    tb_oready = 1'b1;
    for (int k = 7; k <= 16; k++) send(w16(k));
    drain("stall_drain");
    idle(4);
    chk("stall_frame_done_count", 32'(fd_cnt - f0), 32'd1);

    // Reset mid-frame after 6 beats, then a fresh full frame.
    sel = 2'd0; tb_oready = 1'b1;
    for (int k = 1; k <= 6; k++) send(w16(k));
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(cur_oval), 32'd0);
    chk("midrst_in_ready", 32'(cur_irdy), 32'd1);
    idle(2);
    reset = 1'b0;
    idle(1);
    apply_vec(0);
    idle(4);

    // Three back-to-back random 28x28 frames with random valid/ready.
    sel = 2'd3; f0 = fd_cnt;
    rnd_en = 1'b1;
    fork
      while (rnd_en) begin
        @(posedge clk);
        #1;
        tb_oready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 784; k++) frm[k] = 16'($urandom);
      for (int r = 0; r < 14; r++) begin
        for (int c = 0; c < 14; c++) begin
          m = sx(frm[(2*r)*28 + 2*c]);
          if (sx(frm[(2*r)*28 + 2*c + 1]) > m) m = sx(frm[(2*r)*28 + 2*c + 1]);
          if (sx(frm[(2*r+1)*28 + 2*c]) > m) m = sx(frm[(2*r+1)*28 + 2*c]);
          if (sx(frm[(2*r+1)*28 + 2*c + 1]) > m) m = sx(frm[(2*r+1)*28 + 2*c + 1]);
          sbq.push_back({w16(relu(m)), (r == 13) && (c == 13)});
        end
      end
      for (int k = 0; k < 784; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send(w16(int'(frm[k])));
      end
    end
    rnd_en = 1'b0;
    idle(2);
    tb_oready = 1'b1;
    drain("rand_drain");
    idle(4);
    chk("rand_frame_done_count", 32'(fd_cnt - f0), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
